// File: rtl/conv_input_loader_if.sv
// rtl/conv_input_loader_if.sv - host word stream into the input loader
interface conv_input_loader_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/conv_input_loader.sv
// rtl/conv_input_loader.sv - lays host images into input SRAM, then starts the engine
module conv_input_loader #(
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = 16,
   parameter int                MIN_DIM   = 3,
   parameter int                MAX_ROWS  = 16,
   parameter logic [DATA_W-1:0] TERM_WORD = 16'h00FF
) (
   input  logic                clk,
   input  logic                reset_b,
   conv_input_loader_if.slave  s_in,
   input  logic                batch_end,
   output logic [ADDR_W-1:0]   loader_sram_write_address,
   output logic [DATA_W-1:0]   loader_sram_write_data,
   output logic                loader_sram_write_enable,
   output logic                dut_run,
   input  logic                dut_busy,
   output logic [7:0]          images_loaded,
   output logic                err_dim,
   output logic                err_len,
   output logic                err_ovf,
   output logic                batch_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR_R, S_HDR_C, S_WR_R, S_WR_C, S_ROWS,
      S_DROP, S_TERM, S_RUN, S_WAIT_HI, S_WAIT_LO, S_DONE
   } state_t;

   localparam int                SUM_W     = ADDR_W + 1;
   localparam logic [SUM_W-1:0]  OVF_LIMIT = SUM_W'((1 << ADDR_W) - 2);
   localparam logic [DATA_W-1:0] MIN_D     = DATA_W'(MIN_DIM);
   localparam logic [DATA_W-1:0] MAX_R     = DATA_W'(MAX_ROWS);
   localparam logic [DATA_W-1:0] MAX_C     = DATA_W'(DATA_W);
   localparam logic [DATA_W-1:0] ONE_D     = DATA_W'(1);
   localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TWO_A     = ADDR_W'(2);

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_nrows;
   logic [DATA_W-1:0]   r_ncols;
   logic [DATA_W-1:0]   r_row_cnt;
   logic [ADDR_W-1:0]   r_img_base;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [7:0]          r_images;
   logic                r_err_dim;
   logic                r_err_len;
   logic                r_err_ovf;
   logic                r_we;
   logic [ADDR_W-1:0]   r_waddr;
   logic [DATA_W-1:0]   r_wdata;

   logic                w_in_ready;
   logic                w_xfer;
   logic                w_dim_bad;
   logic [SUM_W-1:0]    w_need;
   logic                w_no_space;
   logic                w_last_row;
   logic                w_we;
   logic [ADDR_W-1:0]   w_waddr;
   logic [DATA_W-1:0]   w_wdata;
   logic                w_set_dim;
   logic                w_set_len;
   logic                w_set_ovf;
   logic                w_commit;
   logic                w_rewind;
   logic                w_row_wr;
   logic                w_ptr_init;
   logic                w_ld_nrows;
   logic                w_ld_ncols;

   // batch_end pre-empts a header word: nothing is accepted in that cycle
   assign w_in_ready = ((r_state == S_HDR_R) && !batch_end) || (r_state == S_HDR_C)
                     || (r_state == S_ROWS) || (r_state == S_DROP);
   assign w_xfer     = s_in.in_valid && w_in_ready;
   assign w_dim_bad  = (r_nrows < MIN_D) || (r_nrows > MAX_R)
                     || (s_in.in_data < MIN_D) || (s_in.in_data > MAX_C);
   // one bit wider than the address so the space check never wraps
   assign w_need     = SUM_W'(r_img_base) + SUM_W'(r_nrows) + SUM_W'(2);
   assign w_no_space = w_need > OVF_LIMIT;
   assign w_last_row = (r_row_cnt + ONE_D) == r_nrows;

   always_ff @(posedge clk) begin
      if (reset_b) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_we       = 1'b0;
      w_waddr    = r_img_base;
      w_wdata    = r_nrows;
      w_set_dim  = 1'b0;
      w_set_len  = 1'b0;
      w_set_ovf  = 1'b0;
      w_commit   = 1'b0;
      w_rewind   = 1'b0;
      w_row_wr   = 1'b0;
      w_ptr_init = 1'b0;
      w_ld_nrows = 1'b0;
      w_ld_ncols = 1'b0;
      case (r_state)
         S_IDLE:  w_next = S_HDR_R;
         S_HDR_R: begin
            if (batch_end) begin
               w_next = S_TERM;
            end else if (w_xfer) begin
               w_ld_nrows = 1'b1;
               w_next     = S_HDR_C;
            end
         end
         S_HDR_C: begin
            if (w_xfer) begin
               w_ld_ncols = 1'b1;
               if (w_dim_bad) begin
                  w_set_dim = 1'b1;
                  w_next    = S_DROP;
               end else if (w_no_space) begin
                  w_set_ovf = 1'b1;
                  w_next    = S_DROP;
               end else begin
                  w_next = S_WR_R;
               end
            end
         end
         S_WR_R: begin
            w_we   = 1'b1;
            w_next = S_WR_C;
         end
         S_WR_C: begin
            w_we       = 1'b1;
            w_waddr    = r_img_base + ONE_A;
            w_wdata    = r_ncols;
            w_ptr_init = 1'b1;
            w_next     = S_ROWS;
         end
         S_ROWS: begin
            if (w_xfer) begin
               w_we     = 1'b1;
               w_waddr  = r_wr_ptr;
               w_wdata  = s_in.in_data;
               w_row_wr = 1'b1;
               if (s_in.in_last && w_last_row) begin
                  w_commit = 1'b1;
                  w_next   = S_HDR_R;
               end else if (s_in.in_last) begin
                  w_set_len = 1'b1;
                  w_rewind  = 1'b1;
                  w_next    = S_HDR_R;
               end else if (w_last_row) begin
                  w_set_len = 1'b1;
                  w_rewind  = 1'b1;
                  w_next    = S_DROP;
               end
            end
         end
         S_DROP: begin
            if (w_xfer && s_in.in_last) w_next = S_HDR_R;
         end
         S_TERM: begin
            w_we    = 1'b1;
            w_wdata = TERM_WORD;
            w_next  = S_RUN;
         end
         S_RUN:     w_next = S_WAIT_HI;
         S_WAIT_HI: if (dut_busy)  w_next = S_WAIT_LO;
         S_WAIT_LO: if (!dut_busy) w_next = S_DONE;
         S_DONE:    w_next = S_DONE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_b) begin
         r_nrows    <= '0;
         r_ncols    <= '0;
         r_row_cnt  <= '0;
         r_img_base <= '0;
         r_wr_ptr   <= '0;
         r_images   <= '0;
         r_err_dim  <= 1'b0;
         r_err_len  <= 1'b0;
         r_err_ovf  <= 1'b0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
      end else begin
         if (w_ld_nrows) r_nrows <= s_in.in_data;
         if (w_ld_ncols) r_ncols <= s_in.in_data;
         if (w_ptr_init) begin
            r_wr_ptr  <= r_img_base + TWO_A;
            r_row_cnt <= '0;
         end else if (w_rewind) begin
            r_wr_ptr <= r_img_base;
         end else if (w_row_wr) begin
            r_wr_ptr  <= r_wr_ptr + ONE_A;
            r_row_cnt <= r_row_cnt + ONE_D;
         end
         if (w_commit) begin
            r_img_base <= r_wr_ptr + ONE_A;
            if (r_images != 8'hFF) r_images <= r_images + 8'd1;
         end
         if (w_set_dim) r_err_dim <= 1'b1;
         if (w_set_len) r_err_len <= 1'b1;
         if (w_set_ovf) r_err_ovf <= 1'b1;
         r_we <= w_we;
         if (w_we) begin
            r_waddr <= w_waddr;
            r_wdata <= w_wdata;
         end
      end
   end

   assign s_in.in_ready             = w_in_ready;
   assign loader_sram_write_enable  = r_we;
   assign loader_sram_write_address = r_waddr;
   assign loader_sram_write_data    = r_wdata;
   assign dut_run                   = (r_state == S_RUN);
   assign batch_done                = (r_state == S_DONE);
   assign images_loaded             = r_images;
   assign err_dim                   = r_err_dim;
   assign err_len                   = r_err_len;
   assign err_ovf                   = r_err_ovf;

endmodule

// File: tb/tb_conv_input_loader.sv
// tb/tb_conv_input_loader.sv - directed vector bench for conv_input_loader
module tb_conv_input_loader;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        batch_end;
   logic        dut_busy;
   logic [11:0] waddr;
   logic [15:0] wdata;
   logic        we;
   logic        dut_run;
   logic [7:0]  images_loaded;
   logic        err_dim;
   logic        err_len;
   logic        err_ovf;
   logic        batch_done;

   always #5 clk = ~clk;

   conv_input_loader_if #(.DATA_W(16)) bus ();

   conv_input_loader dut (
      .clk                       (clk),
      .reset_b                   (reset_b),
      .s_in                      (bus),
      .batch_end                 (batch_end),
      .loader_sram_write_address (waddr),
      .loader_sram_write_data    (wdata),
      .loader_sram_write_enable  (we),
      .dut_run                   (dut_run),
      .dut_busy                  (dut_busy),
      .images_loaded             (images_loaded),
      .err_dim                   (err_dim),
      .err_len                   (err_len),
      .err_ovf                   (err_ovf),
      .batch_done                (batch_done)
   );

   int          total = 0;
   int          bad = 0;
   int          wr_cnt = 0;
   int          run_cnt = 0;
   logic [15:0] mem [0:4095];

   // SRAM model and run-pulse counter, sampled just after the rising edge
   always begin
      @(posedge clk);
      #1;
      if (we) begin
         mem[waddr] = wdata;
         wr_cnt++;
      end
      if (dut_run) run_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      int         nr;
      int         nc;
      int         nsend;
      int         last_at;
      int         exp_dw;
      int         exp_base;
      int         exp_ld;
      logic [2:0] exp_err;
      int         exp_stall;
      bit         commit;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] row_val(input int img, input int k);
      return 16'((img << 8) + k + 1);
   endfunction

   task automatic send(input logic [15:0] d, input logic l, output int waits);
      waits = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      #1;
      while (!bus.in_ready && waits < 100) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!bus.in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_image(input int nr, input int nc, input int nsend, input int last_at,
                             input int img, output int stalls);
      int w;
      stalls = 0;
      send(16'(nr), 1'b0, w);
      send(16'(nc), 1'b0, w);
      for (int k = 1; k <= nsend; k++) begin
         send(row_val(img, k), (k == last_at), w);
         stalls += w;
      end
      if (last_at == 0) send(16'hBEEF, 1'b1, w);
   endtask

   task automatic end_batch();
      batch_end = 1'b1;
      @(negedge clk);
      batch_end = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      reset_b      = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
      batch_end    = 1'b0;
      dut_busy     = 1'b0;
      repeat (3) @(negedge clk);
      reset_b = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_waddr"}, waddr, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_run"}, dut_run, 0);
      chk({tag, "_loaded"}, images_loaded, 0);
      chk({tag, "_errs"}, {err_dim, err_len, err_ovf}, 0);
      chk({tag, "_done"}, batch_done, 0);
   endtask

   initial begin
      int          st;
      int          base;
      int          rbase;
      int          n;
      logic [15:0] exp_b [7];

      tbl[0] = '{2,  5,  2,  2,  0,  0, 0, 3'b100, 0, 1'b0};
      tbl[1] = '{17, 5,  1,  1,  0,  0, 0, 3'b100, 0, 1'b0};
      tbl[2] = '{3,  17, 1,  1,  0,  0, 0, 3'b100, 0, 1'b0};
      tbl[3] = '{3,  3,  3,  3,  5,  0, 1, 3'b100, 2, 1'b1};
      tbl[4] = '{5,  4,  3,  3,  5,  5, 1, 3'b110, 2, 1'b0};
      tbl[5] = '{4,  4,  4,  0,  6,  5, 1, 3'b110, 2, 1'b0};
      tbl[6] = '{16, 16, 16, 16, 18, 5, 2, 3'b110, 2, 1'b1};
      exp_b = '{16'd4, 16'd5, 16'h001F, 16'h0011, 16'h0011, 16'h001F, 16'h00FF};

      // reset values while reset is held
      reset_b      = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
      batch_end    = 1'b0;
      dut_busy     = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_b = 1'b0;

      // single 4x5 image, terminator, engine handshake
      base = wr_cnt;
      send(16'd4, 1'b0, st);
      send(16'd5, 1'b0, st);
      send(16'h001F, 1'b0, st);
      send(16'h0011, 1'b0, st);
      send(16'h0011, 1'b0, st);
      send(16'h001F, 1'b1, st);
      end_batch();
      for (int a = 0; a < 7; a++) chk($sformatf("img1_mem%0d", a), mem[a], exp_b[a]);
      chk("img1_writes", wr_cnt - base, 7);
      chk("img1_loaded", images_loaded, 1);
      chk("img1_errs", {err_dim, err_len, err_ovf}, 0);
      n = 0;
      while (run_cnt == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("run_seen", (run_cnt > 0), 1);
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         dut_busy = (i >= 3 && i <= 20);
         #1;
         if (i == 21) chk("done_before_busy_fall", batch_done, 0);
         if (i == 22) chk("done_after_busy_fall", batch_done, 1);
      end
      repeat (5) @(negedge clk);
      chk("done_holds", batch_done, 1);
      chk("run_pulses", run_cnt, 1);

      // table of images: illegal dims, good, early in_last, missing in_last
      do_reset();
      for (int i = 0; i < 7; i++) begin
         base = wr_cnt;
         send_image(tbl[i].nr, tbl[i].nc, tbl[i].nsend, tbl[i].last_at, i, st);
         @(negedge clk);
         chk($sformatf("vec%0d_writes", i), wr_cnt - base, tbl[i].exp_dw);
         chk($sformatf("vec%0d_loaded", i), images_loaded, tbl[i].exp_ld);
         chk($sformatf("vec%0d_errs", i), {err_dim, err_len, err_ovf}, tbl[i].exp_err);
         chk($sformatf("vec%0d_stalls", i), st, tbl[i].exp_stall);
         if (tbl[i].exp_dw > 0)
            chk($sformatf("vec%0d_nrows_at_base", i), mem[tbl[i].exp_base], tbl[i].nr);
         if (tbl[i].commit) begin
            chk($sformatf("vec%0d_ncols", i), mem[tbl[i].exp_base + 1], tbl[i].nc);
            for (int k = 1; k <= tbl[i].nr; k++)
               chk($sformatf("vec%0d_row%0d", i, k), mem[tbl[i].exp_base + 1 + k], row_val(i, k));
         end
      end
      base = wr_cnt;
      end_batch();
      chk("tbl_term_writes", wr_cnt - base, 1);
      chk("tbl_term_word", mem[23], 16'h00FF);

      // reset in the middle of ROWS, then a fresh image from address 0
      do_reset();
      send_image(4, 4, 4, 4, 20, st);
      chk("pre_rst_loaded", images_loaded, 1);
      send(16'd4, 1'b0, st);
      send(16'd4, 1'b0, st);
      send(16'h1111, 1'b0, st);
      send(16'h2222, 1'b0, st);
      reset_b = 1'b1;
      @(negedge clk);
      chk_all_zero("midrst");
      reset_b = 1'b0;
      base = wr_cnt;
      send_image(3, 3, 3, 3, 30, st);
      end_batch();
      chk("fresh_writes", wr_cnt - base, 6);
      chk("fresh_nrows", mem[0], 3);
      chk("fresh_row3", mem[4], row_val(30, 3));
      chk("fresh_term", mem[5], 16'h00FF);

      // fill SRAM to the edge: saturation, then overflow boundary
      do_reset();
      base = wr_cnt;
      for (int i = 0; i < 816; i++) send_image(3, 3, 3, 3, i, st);
      @(negedge clk);
      chk("fill_writes", wr_cnt - base, 4080);
      chk("fill_loaded_sat", images_loaded, 255);
      chk("fill_errs", {err_dim, err_len, err_ovf}, 0);
      base = wr_cnt;
      send_image(13, 3, 1, 1, 900, st);
      @(negedge clk);
      chk("ovf_writes", wr_cnt - base, 0);
      chk("ovf_errs", {err_dim, err_len, err_ovf}, 3'b001);
      rbase = wr_cnt;
      send_image(12, 3, 12, 12, 901, st);
      @(negedge clk);
      chk("edge_writes", wr_cnt - rbase, 14);
      chk("edge_nrows", mem[4080], 12);
      chk("edge_last_row", mem[4093], row_val(901, 12));
      chk("edge_loaded", images_loaded, 255);
      end_batch();
      chk("edge_term", mem[4094], 16'h00FF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
